// File: rtl/nom_pkg.sv
// Shared definitions for the neuron output module: sweep states, NR field layout
// and the helper that splices a new accumulator value into an NR word.
package nom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EV,
        EMIT,
        WR,
        DONE
    } nom_state_e;

    // Field placement shared with the input accumulator so both agree on the layout.
    localparam int NOM_ACC_LSB   = 40;
    localparam int NOM_ACC_WIDTH = 16;
    localparam int NOM_WORD_MAX  = 64;

    // Words and values are zero-extended to NOM_WORD_MAX so one function serves any NR_WIDTH.
    function automatic logic [NOM_WORD_MAX-1:0] nom_replace_acc(
        input logic [NOM_WORD_MAX-1:0] word,
        input logic [NOM_WORD_MAX-1:0] acc,
        input int                      lsb,
        input int                      width
    );
        logic [NOM_WORD_MAX-1:0] mask;
        mask = ((64'd1 << width) - 64'd1) << lsb;
        return (word & ~mask) | ((acc << lsb) & mask);
    endfunction

endpackage

// File: rtl/nom_spike_eval.sv
// Combinational fire decision and write-back word generation for one NR entry.
// With NOM_LEAK_EN defined, non-firing accumulators are reduced by leak, saturating at 0.
module nom_spike_eval
    import nom_pkg::*;
#(
    parameter int NR_WIDTH  = 56,
    parameter int ACC_LSB   = NOM_ACC_LSB,
    parameter int ACC_WIDTH = NOM_ACC_WIDTH
) (
    input  logic [NR_WIDTH-1:0]  word_i,
    input  logic [ACC_WIDTH-1:0] threshold_i,
    input  logic [ACC_WIDTH-1:0] leak_i,
    output logic                 fire_o,
    output logic [NR_WIDTH-1:0]  newWord_o
);

    logic [ACC_WIDTH-1:0]    acc;
    logic [ACC_WIDTH-1:0]    newAcc;
    logic [NOM_WORD_MAX-1:0] merged;

    assign acc    = word_i[ACC_LSB +: ACC_WIDTH];
    assign fire_o = (acc >= threshold_i);

`ifdef NOM_LEAK_EN
    assign newAcc = fire_o ? '0 : ((acc > leak_i) ? (acc - leak_i) : '0);
`else
    logic unused_leak;
    assign unused_leak = ^leak_i;
    // Only firing neurons reach write-back, so the field is always cleared.
    assign newAcc = '0;
`endif

    assign merged    = nom_replace_acc(NOM_WORD_MAX'(word_i), NOM_WORD_MAX'(newAcc), ACC_LSB, ACC_WIDTH);
    assign newWord_o = merged[NR_WIDTH-1:0];

    generate
        if (NR_WIDTH < NOM_WORD_MAX) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^merged[NOM_WORD_MAX-1:NR_WIDTH];
        end
    endgenerate

endmodule

// File: rtl/neuron_output_module.sv
// Sweeps the neuron register file, emits spikes for neurons at/above threshold and
// clears them; optional leak write-back of non-firing neurons is enabled by NOM_LEAK_EN.
module neuron_output_module
    import nom_pkg::*;
#(
    parameter int NR_WIDTH  = 56,
    parameter int NR_DEPTH  = 16,
    parameter int ACC_LSB   = NOM_ACC_LSB,
    parameter int ACC_WIDTH = NOM_ACC_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ACC_WIDTH-1:0]          threshold,
    input  logic [ACC_WIDTH-1:0]          leak,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NR_DEPTH+1)-1:0] fire_count,
    input  logic [NR_WIDTH-1:0]           nr_read,
    output logic [NR_WIDTH-1:0]           nr_write,
    output logic                          nr_we,
    output logic [$clog2(NR_DEPTH)-1:0]   nr_addr,
    output logic                          spike_valid,
    input  logic                          spike_ready,
    output logic [$clog2(NR_DEPTH)-1:0]   spike_id
);

    localparam int IW = $clog2(NR_DEPTH);
    localparam int CW = $clog2(NR_DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NR_DEPTH - 1);

    nom_state_e           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NR_WIDTH-1:0]  word_q, word_d;
    logic [ACC_WIDTH-1:0] thresh_q, thresh_d;
    logic [ACC_WIDTH-1:0] leak_q, leak_d;

    logic [NR_WIDTH-1:0]  evalWord;
    logic [NR_WIDTH-1:0]  newWord;
    logic                 fire;
    logic                 advance;

    // EV decides on the live read data; WR rebuilds from the captured word.
    assign evalWord = (state_q == EV) ? nr_read : word_q;

    nom_spike_eval #(
        .NR_WIDTH (NR_WIDTH),
        .ACC_LSB  (ACC_LSB),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_eval (
        .word_i     (evalWord),
        .threshold_i(thresh_q),
        .leak_i     (leak_q),
        .fire_o     (fire),
        .newWord_o  (newWord)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            thresh_q <= '0;
            leak_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            thresh_q <= thresh_d;
            leak_q   <= leak_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        thresh_d    = thresh_q;
        leak_d      = leak_q;
        advance     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        nr_we       = 1'b0;
        nr_addr     = '0;
        nr_write    = '0;
        spike_valid = 1'b0;
        spike_id    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    thresh_d = threshold;
                    leak_d   = leak;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = RD;
                end
            end
            RD: begin
                busy    = 1'b1;
                nr_addr = idx_q;
                state_d = EV;
            end
            EV: begin
                busy   = 1'b1;
                word_d = nr_read;
                if (fire) begin
                    state_d = EMIT;
                end else begin
`ifdef NOM_LEAK_EN
                    state_d = WR;
`else
                    advance = 1'b1;
`endif
                end
            end
            EMIT: begin
                busy        = 1'b1;
                spike_valid = 1'b1;
                spike_id    = idx_q;
                if (spike_ready) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = WR;
                end
            end
            WR: begin
                busy     = 1'b1;
                nr_we    = 1'b1;
                nr_addr  = idx_q;
                nr_write = newWord;
                advance  = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = RD;
            end
        end
    end

    assign fire_count = cnt_q;

endmodule

// File: tb/tb_neuron_output_module.sv
// Scoreboard bench for neuron_output_module with a synchronous NR model.
// Expectations adapt to builds with NOM_LEAK_EN defined.
module tb_neuron_output_module;

    localparam int NR_WIDTH = 56;
    localparam int NR_DEPTH = 16;
`ifdef NOM_LEAK_EN
    localparam bit LEAK = 1'b1;
`else
    localparam bit LEAK = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  addr;
        logic [55:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] threshold;
    logic [15:0] leak;
    logic        busy;
    logic        done;
    logic [4:0]  fireCount;
    logic [55:0] nrRead;
    logic [55:0] nrWrite;
    logic        nrWe;
    logic [3:0]  nrAddr;
    logic        spikeValid;
    logic        spikeReady;
    logic [3:0]  spikeId;

    logic [55:0] mem   [NR_DEPTH];
    logic [55:0] image [NR_DEPTH];
    logic        loadReq;

    int  expSpikes[$];
    wr_t expWrites[$];
    int  nChecks = 0;
    int  nFails = 0;
    int  validCycles = 0;
    int  weCycles = 0;
    int  doneCount = 0;
    int  doneBase = 0;
    int  cycles;
    logic       spikeHeld = 1'b0;
    logic [3:0] heldId = '0;

    always #5 clk = ~clk;

    neuron_output_module #(
        .NR_WIDTH (NR_WIDTH),
        .NR_DEPTH (NR_DEPTH),
        .ACC_LSB  (40),
        .ACC_WIDTH(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .threshold  (threshold),
        .leak       (leak),
        .busy       (busy),
        .done       (done),
        .fire_count (fireCount),
        .nr_read    (nrRead),
        .nr_write   (nrWrite),
        .nr_we      (nrWe),
        .nr_addr    (nrAddr),
        .spike_valid(spikeValid),
        .spike_ready(spikeReady),
        .spike_id   (spikeId)
    );

    // Synchronous NR: read data one cycle after the address, write in the WR cycle.
    always @(posedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < NR_DEPTH; i++) mem[i] <= image[i];
        end else if (nrWe) begin
            mem[nrAddr] <= nrWrite;
        end
        nrRead <= mem[nrAddr];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [55:0] mkWord(input logic [15:0] acc, input int i);
        return {acc, 8'(8'(i) + 8'h30), 32'(32'hC0DE_0000 + 32'(i))};
    endfunction

    task automatic fillImage(input logic [15:0] acc);
        for (int i = 0; i < NR_DEPTH; i++) image[i] = mkWord(acc, i);
    endtask

    task automatic loadImage();
        @(negedge clk) loadReq = 1'b1;
        @(negedge clk) loadReq = 1'b0;
    endtask

    // Expected spikes and write-backs for one sweep of the current image.
    task automatic planSweep(input logic [15:0] thr, input logic [15:0] lk);
        logic [15:0] acc;
        wr_t w;
        for (int i = 0; i < NR_DEPTH; i++) begin
            acc    = image[i][55:40];
            w.addr = 4'(i);
            if (acc >= thr) begin
                expSpikes.push_back(i);
                w.data = {16'h0000, image[i][39:0]};
                expWrites.push_back(w);
            end else if (LEAK) begin
                w.data = {(acc > lk) ? 16'(acc - lk) : 16'h0000, image[i][39:0]};
                expWrites.push_back(w);
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] thr, input logic [15:0] lk, output int nCyc);
        planSweep(thr, lk);
        validCycles = 0;
        weCycles    = 0;
        doneBase    = doneCount;
        @(negedge clk);
        threshold = thr;
        leak      = lk;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nCyc = 1;
        @(negedge clk);
        checkOutput("busy after start", 64'(busy), 64'd1);
        checkOutput("first nr_addr", 64'(nrAddr), 64'd0);
        while (!done && nCyc < 2000) begin
            @(posedge clk);
            nCyc++;
            @(negedge clk);
        end
        if (!done) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL sweep timeout: got no done after %0d cycles, expected done", nCyc);
        end else begin
            checkOutput("busy at done", 64'(busy), 64'd0);
        end
    endtask

    task automatic checkSweep(input int nCyc, input int expCycles, input int expFire, input int expValid, input int expWe);
        checkOutput("sweep cycles", 64'(nCyc), 64'(expCycles));
        checkOutput("fire_count", 64'(fireCount), 64'(expFire));
        repeat (2) @(negedge clk);
        checkOutput("done pulses", 64'(doneCount - doneBase), 64'd1);
        checkOutput("spike_valid cycles", 64'(validCycles), 64'(expValid));
        checkOutput("nr_we cycles", 64'(weCycles), 64'(expWe));
        checkOutput("spikes pending", 64'(expSpikes.size()), 64'd0);
        checkOutput("writes pending", 64'(expWrites.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a spike or an NR write.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (reset) begin
                spikeHeld = 1'b0;
            end else begin
                if (spikeValid) begin
                    validCycles++;
                    if (spikeHeld) checkOutput("spike_id hold", 64'(spikeId), 64'(heldId));
                    spikeHeld = 1'b1;
                    heldId    = spikeId;
                    if (spikeReady) begin
                        spikeHeld = 1'b0;
                        if (expSpikes.size() == 0) begin
                            nChecks++;
                            nFails++;
                            $display("[TB] FAIL spike_id: got %0d, expected no spike", spikeId);
                        end else begin
                            checkOutput("spike_id", 64'(spikeId), 64'(expSpikes.pop_front()));
                        end
                    end
                end
                if (nrWe) begin
                    weCycles++;
                    checkOutput("nr_we with spike_valid", 64'(spikeValid), 64'd0);
                    if (expWrites.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL nr write: got addr %0d data 0x%0h, expected no write", nrAddr, nrWrite);
                    end else begin
                        w = expWrites.pop_front();
                        checkOutput("nr_addr on write", 64'(nrAddr), 64'(w.addr));
                        checkOutput("nr_write", 64'(nrWrite), 64'(w.data));
                    end
                end
                if (done) doneCount++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        reset      = 1'b1;
        start      = 1'b0;
        threshold  = '0;
        leak       = '0;
        spikeReady = 1'b1;
        loadReq    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset fire_count", 64'(fireCount), 64'd0);
        checkOutput("reset nr_we", 64'(nrWe), 64'd0);
        checkOutput("reset nr_addr", 64'(nrAddr), 64'd0);
        checkOutput("reset nr_write", 64'(nrWrite), 64'd0);
        checkOutput("reset spike_valid", 64'(spikeValid), 64'd0);
        checkOutput("reset spike_id", 64'(spikeId), 64'd0);
        @(negedge clk) reset = 1'b0;

        $display("[TB] sweep with no firing");
        fillImage(16'h0010);
        loadImage();
        applyStimulus(16'h0020, 16'h0000, cycles);
        checkSweep(cycles, LEAK ? 49 : 33, 0, 0, LEAK ? 16 : 0);

        $display("[TB] entries 3 and 9 fire");
        fillImage(16'h0005);
        image[3] = mkWord(16'h0100, 3);
        image[9] = mkWord(16'h0100, 9);
        loadImage();
        applyStimulus(16'h0100, 16'h0000, cycles);
        checkSweep(cycles, LEAK ? 51 : 37, 2, 2, LEAK ? 18 : 2);
        checkOutput("entry 3 after fire", 64'(mem[3]), 64'({16'h0000, image[3][39:0]}));
        checkOutput("entry 9 after fire", 64'(mem[9]), 64'({16'h0000, image[9][39:0]}));

        $display("[TB] spike 3 stalled for 5 cycles");
        loadImage();
        spikeReady = 1'b0;
        fork
            applyStimulus(16'h0100, 16'h0000, cycles);
            begin
                w = 0;
                while (!spikeValid && w < 500) begin
                    @(negedge clk);
                    w++;
                end
                repeat (5) @(posedge clk);
                #1 spikeReady = 1'b1;
            end
        join
        checkSweep(cycles, LEAK ? 56 : 42, 2, 7, LEAK ? 18 : 2);

        $display("[TB] leak with threshold all-ones");
        fillImage(16'h0004);
        image[0] = mkWord(16'h0005, 0);
        image[1] = mkWord(16'h0030, 1);
        loadImage();
        applyStimulus(16'hFFFF, 16'h0008, cycles);
        checkSweep(cycles, LEAK ? 49 : 33, 0, 0, LEAK ? 16 : 0);
        checkOutput("entry 0 acc", 64'(mem[0][55:40]), LEAK ? 64'h0000 : 64'h0005);
        checkOutput("entry 1 acc", 64'(mem[1][55:40]), LEAK ? 64'h0028 : 64'h0030);
        checkOutput("entry 1 low bits", 64'(mem[1][39:0]), 64'(image[1][39:0]));

        $display("[TB] threshold zero fires every neuron");
        loadImage();
        applyStimulus(16'h0000, 16'h0000, cycles);
        checkSweep(cycles, 65, 16, 16, 16);

        $display("[TB] threshold all-ones fires only saturated accumulators");
        fillImage(16'hFFFE);
        image[7] = mkWord(16'hFFFF, 7);
        loadImage();
        applyStimulus(16'hFFFF, 16'h0000, cycles);
        checkSweep(cycles, LEAK ? 50 : 35, 1, 1, LEAK ? 16 : 1);

        $display("[TB] start pulsed while busy");
        fillImage(16'h0010);
        loadImage();
        fork
            applyStimulus(16'h0020, 16'h0000, cycles);
            begin
                repeat (12) @(posedge clk);
                #1;
                threshold = 16'h0000;
                start     = 1'b1;
                @(posedge clk);
                #1;
                start     = 1'b0;
                threshold = 16'h0020;
            end
        join
        checkSweep(cycles, LEAK ? 49 : 33, 0, 0, LEAK ? 16 : 0);

        $display("[TB] reset during EMIT of neuron 5");
        fillImage(16'h0001);
        image[5] = mkWord(16'h0200, 5);
        loadImage();
        spikeReady = 1'b0;
        @(negedge clk);
        threshold = 16'h0100;
        leak      = 16'h0000;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        w = 0;
        while (!spikeValid && w < 200) begin
            @(negedge clk);
            w++;
        end
        checkOutput("spike_id before reset", 64'(spikeId), 64'd5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort spike_valid", 64'(spikeValid), 64'd0);
        checkOutput("abort spike_id", 64'(spikeId), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort nr_we", 64'(nrWe), 64'd0);
        checkOutput("abort fire_count", 64'(fireCount), 64'd0);
        @(negedge clk);
        reset      = 1'b0;
        spikeReady = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("entry 5 after abort", 64'(mem[5]), 64'(image[5]));
        applyStimulus(16'h0100, 16'h0000, cycles);
        checkSweep(cycles, LEAK ? 50 : 35, 1, 1, LEAK ? 16 : 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
